// File: rtl/lut_config_loader_pkg.sv
// Shared definitions for the LUT configuration loader: FSM encoding and
// helpers for deriving chunk count and counter width.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    PASS   = 2'd3
  } state_t;

  function automatic int calc_nwords(input int mem_size, input int word);
    return mem_size / word;
  endfunction

  // A single-chunk table still needs a 1-bit counter.
  function automatic int cnt_width(input int nwords);
    return ($clog2(nwords) < 1) ? 1 : $clog2(nwords);
  endfunction

endpackage

// File: rtl/lut_config_loader_if.sv
// Stream and LUT-facing signals of the configuration loader, bundled so the
// upstream driver and the loader share one connection.
interface lut_config_loader_if #(
  parameter int INPUTS = 4,
  parameter int WORD   = 4
);
  localparam int MEM_SIZE = 2 ** INPUTS;

  logic                cfg_start;
  logic                in_valid;
  logic                in_ready;
  logic [WORD-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [WORD-1:0]     out_data;
  logic [MEM_SIZE-1:0] config_in;
  logic                cen;
  logic                cfg_done;

  modport master (
    output cfg_start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, config_in, cen, cfg_done
  );

  modport slave (
    input  cfg_start, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, config_in, cen, cfg_done
  );

endinterface

// File: rtl/lut_config_loader.sv
// Deserializes a chunked truth-table stream into the LUT, strobes cen once to
// commit it, then forwards later chunks down the daisy chain.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int INPUTS = 4,
  parameter int WORD   = 4
) (
  input  logic                cclk,
  input  logic                rst_n,
  lut_config_loader_if.slave  bus
);

  localparam int MEM_SIZE = 2 ** INPUTS;
  localparam int NWORDS   = calc_nwords(MEM_SIZE, WORD);
  localparam int CW       = cnt_width(NWORDS);

  if (MEM_SIZE % WORD != 0) begin : g_bad_word
    $error("lut_config_loader: WORD must divide MEM_SIZE exactly");
  end

  state_t              state;
  logic [MEM_SIZE-1:0] shreg;
  logic [CW-1:0]       count;
  logic                cen_r;
  logic                done_r;

  // cfg_start outranks every state, and the chunk offered alongside it is
  // refused so a restart never absorbs a stale word.
  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      count  <= '0;
      cen_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cen_r <= 1'b0;
      if (bus.cfg_start) begin
        state  <= LOAD;
        shreg  <= '0;
        count  <= '0;
        done_r <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          LOAD: begin
            if (bus.in_valid) begin
              shreg <= {shreg[MEM_SIZE-WORD-1:0], bus.in_data};
              if (count == CW'(NWORDS - 1)) begin
                count <= '0;
                state <= COMMIT;
                cen_r <= 1'b1;
              end else begin
                count <= count + 1'b1;
              end
            end
          end
          COMMIT: begin
            state  <= PASS;
            done_r <= 1'b1;
          end
          PASS:    state <= PASS;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = !bus.cfg_start &&
                         ((state == LOAD) || ((state == PASS) && bus.out_ready));
  assign bus.out_valid = !bus.cfg_start && (state == PASS) && bus.in_valid;
  assign bus.out_data  = bus.in_data;
  assign bus.config_in = shreg;
  assign bus.cen       = cen_r;
  assign bus.cfg_done  = done_r;

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench for lut_config_loader: expected tables are queued as loads
// are driven and compared whenever the loader strobes cen.
module tb_lut_config_loader;

  logic cclk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   cenCount = 0;
  int   cenCyc = -1;
  int   startCyc = 0;
  int   doneCyc = -1;
  int   base = 0;
  logic prevCen = 1'b0;
  logic [15:0] expQ[$];

  lut_config_loader_if #(.INPUTS(4), .WORD(4)) bus ();

  lut_config_loader #(.INPUTS(4), .WORD(4)) dut (
    .cclk  (cclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every cen pulse must be a single cycle and must carry the oldest queued table.
  always @(negedge cclk) begin
    if (bus.cen === 1'b1) begin
      cenCount++;
      cenCyc = cyc;
      checkOutput("cen_width", {31'd0, prevCen}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("cen_unexpected", 32'd1, 32'd0);
      end else begin
        checkOutput("config_in", {16'd0, bus.config_in}, {16'd0, expQ.pop_front()});
      end
    end
    prevCen = bus.cen;
  end

  // Called and returning just after a rising edge; offers one chunk until taken.
  task automatic applyStimulus(input logic [3:0] data, input int gap);
    bit taken = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int n = 0; n < 50; n++) begin
      @(negedge cclk);
      taken = (bus.in_ready === 1'b1);
      @(posedge cclk);
      #1;
      if (taken) break;
    end
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge cclk);
      #1;
    end
  endtask

  task automatic startLoad();
    startCyc = cyc;
    bus.cfg_start = 1'b1;
    @(posedge cclk);
    #1;
    bus.cfg_start = 1'b0;
  endtask

  task automatic waitDone();
    doneCyc = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge cclk);
      if (bus.cfg_done === 1'b1) begin
        doneCyc = cyc;
        break;
      end
    end
    if (doneCyc < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    @(posedge cclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h6;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    checkOutput("rst_cen", {31'd0, bus.cen}, 32'd0);
    checkOutput("rst_config", {16'd0, bus.config_in}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.cfg_done}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_out_data", {28'd0, bus.out_data}, 32'h6);
    rst_n = 1'b1;
    @(posedge cclk);
    #1;
    checkOutput("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    $display("[TB] basic load");
    startLoad();
    expQ.push_back(16'hA5C3);
    base = cenCount;
    applyStimulus(4'hA, 0);
    applyStimulus(4'h5, 0);
    applyStimulus(4'hC, 0);
    applyStimulus(4'h3, 0);
    waitDone();
    checkOutput("cen_latency", cenCyc - startCyc, 32'd5);
    checkOutput("done_latency", doneCyc - startCyc, 32'd6);
    checkOutput("basic_cen_count", cenCount - base, 32'd1);

    $display("[TB] stalled load");
    startLoad();
    expQ.push_back(16'hA5C3);
    base = cenCount;
    applyStimulus(4'hA, 3);
    applyStimulus(4'h5, 3);
    checkOutput("stall_hold", {16'd0, bus.config_in}, 32'h00A5);
    checkOutput("stall_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("stall_no_cen", cenCount - base, 32'd0);
    applyStimulus(4'hC, 3);
    applyStimulus(4'h3, 3);
    waitDone();
    checkOutput("stall_cen_count", cenCount - base, 32'd1);

    $display("[TB] abort");
    startLoad();
    base = cenCount;
    applyStimulus(4'hF, 0);
    applyStimulus(4'hF, 0);
    checkOutput("abort_partial", {16'd0, bus.config_in}, 32'h00FF);
    startLoad();
    checkOutput("abort_clear", {16'd0, bus.config_in}, 32'd0);
    expQ.push_back(16'h1234);
    applyStimulus(4'h1, 0);
    applyStimulus(4'h2, 0);
    applyStimulus(4'h3, 0);
    applyStimulus(4'h4, 0);
    waitDone();
    checkOutput("abort_cen_count", cenCount - base, 32'd1);

    $display("[TB] daisy chain");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h7;
    @(negedge cclk);
    checkOutput("pass_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("pass_out_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("pass_out_data", {28'd0, bus.out_data}, 32'h7);
    @(posedge cclk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge cclk);
    checkOutput("pass_in_ready_high", {31'd0, bus.in_ready}, 32'd1);
    @(posedge cclk);
    #1;
    bus.in_valid = 1'b0;
    checkOutput("pass_config_frozen", {16'd0, bus.config_in}, 32'h1234);
    checkOutput("pass_done", {31'd0, bus.cfg_done}, 32'd1);
    @(negedge cclk);
    checkOutput("pass_out_valid_low", {31'd0, bus.out_valid}, 32'd0);
    @(posedge cclk);
    #1;

    $display("[TB] start/valid collision");
    bus.cfg_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h9;
    @(negedge cclk);
    checkOutput("collide_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge cclk);
    #1;
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("collide_config", {16'd0, bus.config_in}, 32'd0);
    checkOutput("collide_done_clr", {31'd0, bus.cfg_done}, 32'd0);
    base = cenCount;
    expQ.push_back(16'h9876);
    applyStimulus(4'h9, 0);
    applyStimulus(4'h8, 0);
    applyStimulus(4'h7, 0);
    checkOutput("collide_count", {31'd0, bus.cen}, 32'd0);
    applyStimulus(4'h6, 0);
    waitDone();
    checkOutput("collide_cen_count", cenCount - base, 32'd1);

    $display("[TB] reset mid-load");
    startLoad();
    base = cenCount;
    applyStimulus(4'hD, 0);
    applyStimulus(4'hE, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h5;
    rst_n = 1'b0;
    @(posedge cclk);
    #1;
    checkOutput("mid_rst_cen", {31'd0, bus.cen}, 32'd0);
    checkOutput("mid_rst_config", {16'd0, bus.config_in}, 32'd0);
    checkOutput("mid_rst_done", {31'd0, bus.cfg_done}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("mid_rst_out_data", {28'd0, bus.out_data}, 32'h5);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge cclk);
      #1;
    end
    checkOutput("mid_rst_no_cen", cenCount - base, 32'd0);
    startLoad();
    expQ.push_back(16'hDEAD);
    applyStimulus(4'hD, 0);
    applyStimulus(4'hE, 0);
    applyStimulus(4'hA, 0);
    applyStimulus(4'hD, 0);
    waitDone();
    checkOutput("reload_cen_count", cenCount - base, 32'd1);

    checkOutput("sb_empty", expQ.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
